// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side packer.
//   BEATW       : width of one packed beat at the default configuration
//   cntw()      : width of a fill counter for a given PACK
//   keep_mask() : lane-keep mask with the low n bits set (callers slice to PACK)
package fifo_pkg;

  localparam int DATASIZE_DEF = 8;
  localparam int PACK_DEF     = 4;
  localparam int BEATW        = DATASIZE_DEF * PACK_DEF;
  localparam int MAXPACK      = 32;

  function automatic int cntw(input int pack);
    return (pack > 1) ? $clog2(pack) : 1;
  endfunction

  localparam int CNTW_DEF = cntw(PACK_DEF);

  function automatic logic [MAXPACK-1:0] keep_mask(input int n);
    logic [MAXPACK-1:0] k;
    k = '0;
    for (int i = 0; i < MAXPACK; i++)
      if (i < n) k[i] = 1'b1;
    return k;
  endfunction

endpackage

// File: rtl/fifo_rd_packer_if.sv
// Packed-beat valid/ready bus.
//   m_data  : PACK lanes of DATASIZE bits, lane 0 in the LSBs
//   m_keep  : per-lane valid mask
//   m_last  : beat was closed by a flush
//   m_valid : beat available (producer -> consumer)
//   m_ready : consumer accepts the beat (consumer -> producer)
interface fifo_rd_packer_if #(
  parameter int DATASIZE = 8,
  parameter int PACK     = 4
);
  logic [DATASIZE*PACK-1:0] m_data;
  logic [PACK-1:0]          m_keep;
  logic                     m_last;
  logic                     m_valid;
  logic                     m_ready;

  modport master (output m_data, m_keep, m_last, m_valid, input m_ready);
  modport slave  (input m_data, m_keep, m_last, m_valid, output m_ready);
endinterface

// File: rtl/pack_out_reg.sv
// Output beat register with valid/ready hold.
//   clk, rst       : clock, synchronous active-high reset
//   load, ld_*     : new beat to capture (caller only loads when out_free=1)
//   m_*            : registered beat toward the consumer
//   out_free       : register empty or being drained this cycle
module pack_out_reg #(
  parameter int BEATW = 32,
  parameter int PACK  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [BEATW-1:0] ld_data,
  input  logic [PACK-1:0]  ld_keep,
  input  logic             ld_last,
  input  logic             m_ready,
  output logic [BEATW-1:0] m_data,
  output logic [PACK-1:0]  m_keep,
  output logic             m_last,
  output logic             m_valid,
  output logic             out_free
);

  assign out_free = !m_valid | m_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_keep  <= '0;
      m_last  <= 1'b0;
    end else if (load) begin
      // Load may coincide with acceptance of the previous beat: no bubble.
      m_valid <= 1'b1;
      m_data  <= ld_data;
      m_keep  <= ld_keep;
      m_last  <= ld_last;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_rd_packer.sv
// Packs PACK consecutive async-FIFO read words into one wide beat.
//   rclk, rrst     : read-domain clock, synchronous active-high reset
//   rdata, rempty  : FIFO head word and empty flag
//   rinc           : pop request (combinational, never while rempty=1)
//   flush          : one-cycle request to emit the partial beat
//   fill           : words currently held in the accumulator
//   m              : packed-beat master bus
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int DATASIZE = 8,
  parameter int PACK     = 4,
  parameter int CNTW     = cntw(PACK)
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic [DATASIZE-1:0] rdata,
  input  logic                rempty,
  output logic                rinc,
  input  logic                flush,
  output logic [CNTW-1:0]     fill,
  fifo_rd_packer_if.master    m
);

  localparam int BW = DATASIZE * PACK;
  localparam logic [CNTW-1:0] LAST = CNTW'(PACK - 1);

  logic [PACK-1:0][DATASIZE-1:0] acc, acc_wr, flush_data;
  logic [PACK-1:0]    keep, ld_keep;
  logic [MAXPACK-1:0] km;
  logic [BW-1:0]      ld_data;
  logic flush_pend, out_free, complete, flush_go, load, ld_last;

  // The last lane may only be written when the finished beat has somewhere
  // to go; earlier lanes keep filling under backpressure.
  assign rinc     = !rrst & !rempty & !flush_pend & ((fill < LAST) | out_free);
  assign complete = rinc & (fill == LAST);
  assign flush_go = flush_pend & out_free;
  assign load     = complete | (flush_go & (fill != '0));

  assign km   = keep_mask(int'(fill));
  assign keep = km[PACK-1:0];

  generate
    if (PACK < MAXPACK) begin : g_km_sink
      logic km_unused;
      assign km_unused = &{1'b0, km[MAXPACK-1:PACK]};
    end
  endgenerate

  always_comb begin
    acc_wr = acc;
    if (rinc) acc_wr[fill] = rdata;
  end

  for (genvar i = 0; i < PACK; i++) begin : g_lane
    assign flush_data[i] = keep[i] ? acc[i] : '0;
  end

  always_comb begin
    ld_data = flush_data;
    ld_keep = keep;
    ld_last = 1'b1;
    if (complete) begin
      ld_data = acc_wr;
      ld_keep = '1;
      ld_last = flush;   // a flush landing on the final word just tags the beat
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      acc        <= '0;
      fill       <= '0;
      flush_pend <= 1'b0;
    end else if (flush_go) begin
      // rinc is held low while pending, so no pop can race this clear.
      // A flush seen in this cycle is absorbed.
      acc        <= '0;
      fill       <= '0;
      flush_pend <= 1'b0;
    end else begin
      if (complete) begin
        acc  <= '0;
        fill <= '0;
      end else if (rinc) begin
        acc  <= acc_wr;
        fill <= fill + 1'b1;
      end
      if (flush && !complete) flush_pend <= 1'b1;
    end
  end

  pack_out_reg #(.BEATW(BW), .PACK(PACK)) u_out (
    .clk      (rclk),
    .rst      (rrst),
    .load     (load),
    .ld_data  (ld_data),
    .ld_keep  (ld_keep),
    .ld_last  (ld_last),
    .m_ready  (m.m_ready),
    .m_data   (m.m_data),
    .m_keep   (m.m_keep),
    .m_last   (m.m_last),
    .m_valid  (m.m_valid),
    .out_free (out_free)
  );

endmodule
